// File: rtl/rst_seq_ctrl_pkg.sv
// Shared definitions for the reset sequencer: FSM state codes and fixed output widths.
package rst_seq_ctrl_pkg;

  localparam int STATE_W         = 3;
  localparam int LOCK_LOSS_CNT_W = 8;

  typedef enum logic [STATE_W-1:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4
  } state_e;

endpackage

// File: rtl/rst_seq_ctrl_sync_2ff.sv
// Two-flop synchronizer for bringing asynchronous level signals into the clk_i domain.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;

  // NOTE: synchronizer flops carry no reset; they flush within two cycles and a reset
  // term would only add a path into the metastability-settling stage.
  always_ff @(posedge clk_i) begin
    meta_q <= d_i;
    q_o    <= meta_q;
  end

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer / PLL supervisor: pulses PLL reset, qualifies lock, releases domain resets in order.
// Optional lock-loss event counter enabled by defining RST_SEQ_LOCK_LOSS_CNT_EN.
module rst_seq_ctrl
  import rst_seq_ctrl_pkg::*;
#(
  parameter int NUM_DOMAINS     = 4,
  parameter int PLL_RST_CNT     = 8,
  parameter int LOCK_STABLE_CNT = 50,
  parameter int DOMAIN_GAP      = 16,
  parameter int LOCK_TIMEOUT    = 65535
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       pll_locked_i,
  input  logic                       sw_rst_req_i,
  output logic                       pll_rst_o,
  output logic [NUM_DOMAINS-1:0]     rst_n_o,
  output logic                       seq_done_o,
  output logic [STATE_W-1:0]         state_o,
  output logic [LOCK_LOSS_CNT_W-1:0] lock_loss_cnt_o
);

  localparam int PR_W = $clog2(PLL_RST_CNT + 1);
  localparam int ST_W = $clog2(LOCK_STABLE_CNT + 1);
  localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);
  localparam int GP_W = $clog2(DOMAIN_GAP + 1);

  localparam logic [PR_W-1:0] PR_LAST = PR_W'(PLL_RST_CNT - 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(LOCK_STABLE_CNT - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [GP_W-1:0] GP_LAST = GP_W'(DOMAIN_GAP - 1);

  logic locked_s;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk_i (clk_i),
    .d_i   (pll_locked_i),
    .q_o   (locked_s)
  );

  state_e                 state_q,    state_d;
  logic [PR_W-1:0]        pr_cnt_q,   pr_cnt_d;
  logic [ST_W-1:0]        st_cnt_q,   st_cnt_d;
  logic [TO_W-1:0]        to_cnt_q,   to_cnt_d;
  logic [GP_W-1:0]        gap_cnt_q,  gap_cnt_d;
  logic                   pll_rst_q,  pll_rst_d;
  logic [NUM_DOMAINS-1:0] rst_n_q,    rst_n_d;
  logic                   seq_done_q, seq_done_d;
  logic                   lock_loss;

  // Lock dropping once any domain may be out of reset is a real loss, not a qualification glitch.
  assign lock_loss = !locked_s && (state_q == S_RELEASE || state_q == S_RUN);

  // NOTE: every next-state variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    pr_cnt_d   = pr_cnt_q;
    st_cnt_d   = st_cnt_q;
    to_cnt_d   = to_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    pll_rst_d  = pll_rst_q;
    rst_n_d    = rst_n_q;
    seq_done_d = 1'b0;

    case (state_q)
      S_PLL_RST: begin
        pll_rst_d = 1'b1;
        rst_n_d   = '0;
        if (pr_cnt_q == PR_LAST) begin
          state_d   = S_WAIT_LOCK;
          pll_rst_d = 1'b0;
          pr_cnt_d  = '0;
          to_cnt_d  = '0;
        end else begin
          pr_cnt_d = pr_cnt_q + PR_W'(1);
        end
      end
      S_WAIT_LOCK: begin
        pll_rst_d = 1'b0;
        if (locked_s) begin
          if (LOCK_STABLE_CNT == 1) begin
            state_d   = S_RELEASE;
            rst_n_d   = NUM_DOMAINS'(1);
            gap_cnt_d = '0;
          end else begin
            state_d  = S_STABLE;
            st_cnt_d = ST_W'(1);
          end
        end else if (to_cnt_q == TO_LAST) begin
          state_d   = S_PLL_RST;
          pll_rst_d = 1'b1;
          pr_cnt_d  = '0;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      S_STABLE: begin
        if (!locked_s) begin
          state_d  = S_WAIT_LOCK;
          to_cnt_d = '0;
        end else if (st_cnt_q == ST_LAST) begin
          state_d   = S_RELEASE;
          rst_n_d   = NUM_DOMAINS'(1);
          gap_cnt_d = '0;
        end else begin
          st_cnt_d = st_cnt_q + ST_W'(1);
        end
      end
      S_RELEASE: begin
        // rst_n_q is a thermometer code; shifting in a one releases the next domain.
        if (rst_n_q[NUM_DOMAINS-1]) begin
          state_d    = S_RUN;
          seq_done_d = 1'b1;
        end else if (gap_cnt_q == GP_LAST) begin
          rst_n_d   = (rst_n_q << 1) | NUM_DOMAINS'(1);
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + GP_W'(1);
        end
      end
      S_RUN: begin
        seq_done_d = 1'b1;
      end
      default: begin
        state_d   = S_PLL_RST;
        pll_rst_d = 1'b1;
        rst_n_d   = '0;
        pr_cnt_d  = '0;
      end
    endcase

    if (sw_rst_req_i || lock_loss) begin
      state_d    = S_PLL_RST;
      pll_rst_d  = 1'b1;
      rst_n_d    = '0;
      seq_done_d = 1'b0;
      pr_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= S_PLL_RST;
      pr_cnt_q   <= '0;
      st_cnt_q   <= '0;
      to_cnt_q   <= '0;
      gap_cnt_q  <= '0;
      pll_rst_q  <= 1'b1;
      rst_n_q    <= '0;
      seq_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pr_cnt_q   <= pr_cnt_d;
      st_cnt_q   <= st_cnt_d;
      to_cnt_q   <= to_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      pll_rst_q  <= pll_rst_d;
      rst_n_q    <= rst_n_d;
      seq_done_q <= seq_done_d;
    end
  end

  assign pll_rst_o  = pll_rst_q;
  assign rst_n_o    = rst_n_q;
  assign seq_done_o = seq_done_q;
  assign state_o    = state_q;

`ifdef RST_SEQ_LOCK_LOSS_CNT_EN
  logic [LOCK_LOSS_CNT_W-1:0] ll_cnt_q;

  // A software request takes priority, so a coincident lock drop is not recorded.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ll_cnt_q <= '0;
    end else if (lock_loss && !sw_rst_req_i && ll_cnt_q != '1) begin
      ll_cnt_q <= ll_cnt_q + LOCK_LOSS_CNT_W'(1);
    end
  end

  assign lock_loss_cnt_o = ll_cnt_q;
`else
  assign lock_loss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl: timeline reference model plus directed timing scenarios.
module tb_rst_seq_ctrl;

  localparam int NUM_DOMAINS     = 4;
  localparam int PLL_RST_CNT     = 8;
  localparam int LOCK_STABLE_CNT = 50;
  localparam int DOMAIN_GAP      = 16;
  localparam int LOCK_TIMEOUT    = 100;
`ifdef RST_SEQ_LOCK_LOSS_CNT_EN
  localparam int LL_EN = 1;
`else
  localparam int LL_EN = 0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic       pll_locked_i;
  logic       sw_rst_req_i;
  logic       pll_rst_o;
  logic [3:0] rst_n_o;
  logic       seq_done_o;
  logic [2:0] state_o;
  logic [7:0] lock_loss_cnt_o;

  rst_seq_ctrl #(
    .NUM_DOMAINS     (NUM_DOMAINS),
    .PLL_RST_CNT     (PLL_RST_CNT),
    .LOCK_STABLE_CNT (LOCK_STABLE_CNT),
    .DOMAIN_GAP      (DOMAIN_GAP),
    .LOCK_TIMEOUT    (LOCK_TIMEOUT)
  ) dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .pll_locked_i    (pll_locked_i),
    .sw_rst_req_i    (sw_rst_req_i),
    .pll_rst_o       (pll_rst_o),
    .rst_n_o         (rst_n_o),
    .seq_done_o      (seq_done_o),
    .state_o         (state_o),
    .lock_loss_cnt_o (lock_loss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  logic [3:0] rel_seen;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference model: phase plus time spent in it; outputs follow from elapsed time.
  int m_phase = 0;
  int m_t     = 0;
  int m_loss  = 0;
  bit lk_hist[$] = '{1'b0, 1'b0};

  task automatic model_step();
    bit ls;
    ls = lk_hist[0];
    void'(lk_hist.pop_front());
    lk_hist.push_back(pll_locked_i === 1'b1);
    if (!rst_n_i) begin
      m_phase = 0; m_t = 0; m_loss = 0;
    end else if (sw_rst_req_i) begin
      m_phase = 0; m_t = 0;
    end else if (m_phase >= 3 && !ls) begin
      m_phase = 0; m_t = 0;
      if (m_loss < 255) m_loss++;
    end else begin
      case (m_phase)
        0: begin
          m_t++;
          if (m_t == PLL_RST_CNT) begin m_phase = 1; m_t = 0; end
        end
        1: begin
          if (ls) begin m_phase = 2; m_t = 1; end
          else begin
            m_t++;
            if (m_t == LOCK_TIMEOUT) begin m_phase = 0; m_t = 0; end
          end
        end
        2: begin
          if (!ls) begin m_phase = 1; m_t = 0; end
          else begin
            m_t++;
            if (m_t == LOCK_STABLE_CNT) begin m_phase = 3; m_t = 0; end
          end
        end
        3: begin
          m_t++;
          if (m_t == (NUM_DOMAINS - 1) * DOMAIN_GAP + 1) begin m_phase = 4; m_t = 0; end
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic [3:0] exp_rst_n();
    int n;
    if (m_phase == 4) return 4'hF;
    if (m_phase != 3) return 4'h0;
    n = 1 + m_t / DOMAIN_GAP;
    if (n > NUM_DOMAINS) n = NUM_DOMAINS;
    return 4'((1 << n) - 1);
  endfunction

  task automatic tick();
    @(posedge clk_i);
    model_step();
    cyc++;
    #1;
    rel_seen |= rst_n_o;
    check("state",    state_o,         m_phase);
    check("pll_rst",  pll_rst_o,       (m_phase == 0));
    check("rst_n",    rst_n_o,         exp_rst_n());
    check("seq_done", seq_done_o,      (m_phase == 4));
    check("loss_cnt", lock_loss_cnt_o, LL_EN * m_loss);
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      0, 1, 2, 3: return rst_n_o[sel];
      4:          return seq_done_o;
      5:          return !pll_rst_o;
      6:          return pll_rst_o;
      default:    return state_o == 3'd1;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int sel, input int max_cyc, output int when);
    bit hit;
    hit  = 1'b0;
    when = -1;
    for (int i = 0; i < max_cyc && !hit; i++) begin
      tick();
      hit = cond(sel);
    end
    if (hit) when = cyc;
    check({tag, "_seen"}, hit, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t_rel, t_lock, t_up, t, tf, tr, tr_prev;
    rel_seen     = '0;
    rst_n_i      = 1'b0;
    pll_locked_i = 1'b0;
    sw_rst_req_i = 1'b0;

    // Power-up
    repeat (5) tick();
    check("rst_state",   state_o,         3'd0);
    check("rst_pll",     pll_rst_o,       1'b1);
    check("rst_domains", rst_n_o,         4'h0);
    check("rst_done",    seq_done_o,      1'b0);
    check("rst_loss",    lock_loss_cnt_o, 8'd0);
    rst_n_i = 1'b1;
    t_rel   = cyc;
    wait_for("pu_pll_fall", 5, 20, tf);
    check("pu_pll_width", tf - t_rel, PLL_RST_CNT);
    while (cyc < t_rel + 20) tick();
    pll_locked_i = 1'b1;
    t_lock = cyc;
    for (int k = 0; k < NUM_DOMAINS; k++) begin
      wait_for("pu_bit", k, 200, t);
      check("pu_bit_lat", t - t_lock, LOCK_STABLE_CNT + 2 + k * DOMAIN_GAP);
    end
    wait_for("pu_done", 4, 10, t);
    check("pu_done_lat", t - t_lock,
          LOCK_STABLE_CNT + 2 + (NUM_DOMAINS - 1) * DOMAIN_GAP + 1);

    // Lock loss in S_RUN
    pll_locked_i = 1'b0;
    tick();
    tick();
    check("ll_hold_state", state_o, 3'd4);
    tick();
    check("ll_domains", rst_n_o,         4'h0);
    check("ll_pll",     pll_rst_o,       1'b1);
    check("ll_state",   state_o,         3'd0);
    check("ll_count",   lock_loss_cnt_o, LL_EN);

    // Lock timeout: PLL re-pulsed, no domain ever released
    rel_seen = '0;
    wait_for("to_fall0", 5, 20, tf);
    wait_for("to_rise1", 6, 200, tr);
    check("to_wait_len", tr - tf, LOCK_TIMEOUT);
    for (int p = 0; p < 2; p++) begin
      tr_prev = tr;
      wait_for("to_fall", 5, 20, tf);
      check("to_pulse_len", tf - tr_prev, PLL_RST_CNT);
      wait_for("to_rise", 6, 200, tr);
      check("to_period", tr - tr_prev, PLL_RST_CNT + LOCK_TIMEOUT);
    end
    check("to_no_release", rel_seen, 4'h0);

    // Lock glitch in S_STABLE at stable count 30
    wait_for("gl_fall", 5, 20, tf);
    pll_locked_i = 1'b1;
    t_up = cyc;
    repeat (30) tick();
    pll_locked_i = 1'b0;
    tick();
    pll_locked_i = 1'b1;
    t_up = cyc;
    wait_for("gl_wait", 7, 10, t);
    check("gl_domains", rst_n_o, 4'h0);
    wait_for("gl_bit0", 0, 200, t);
    check("gl_release_lat", t - t_up, LOCK_STABLE_CNT + 2);
    check("gl_loss", lock_loss_cnt_o, LL_EN);

    // Software request mid S_RELEASE
    wait_for("sw_bit1", 1, 40, t);
    tick();
    sw_rst_req_i = 1'b1;
    tick();
    sw_rst_req_i = 1'b0;
    check("sw_domains", rst_n_o,   4'h0);
    check("sw_state",   state_o,   3'd0);
    check("sw_pll",     pll_rst_o, 1'b1);
    wait_for("sw_rerun", 4, 300, t);
    check("sw_loss", lock_loss_cnt_o, LL_EN);

    // Random lock behaviour and software requests
    for (int seg = 0; seg < 40; seg++) begin
      pll_locked_i = ($urandom_range(0, 3) != 0);
      t = $urandom_range(1, 120);
      for (int i = 0; i < t; i++) begin
        sw_rst_req_i = ($urandom_range(0, 299) == 0);
        tick();
      end
      sw_rst_req_i = 1'b0;
    end

    // Lock-loss saturation
    pll_locked_i = 1'b0;
    repeat (4) tick();
    for (int e = 0; e < 260; e++) begin
      pll_locked_i = 1'b1;
      wait_for("sat_bit0", 0, 300, t);
      pll_locked_i = 1'b0;
      repeat (4) tick();
    end
    check("sat_value", lock_loss_cnt_o, LL_EN * 255);
    rst_n_i = 1'b0;
    tick();
    check("sat_clear", lock_loss_cnt_o, 8'd0);
    check("sat_clear_state", state_o, 3'd0);
    rst_n_i = 1'b1;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
